mvp_issue_ctrl: RTL and testbench

- Upstream driver and result collector for the 4x4-by-vec4 floating-point transform unit.
- Accepts a model-view-projection matrix and a stream of vertices (x,y,z,w as IEEE-754 single) and issues one vertex at a time to the transform unit. The transform unit has no backpressure.
- Captures each transformed vertex into a result FIFO and presents it downstream with a valid/ready handshake.
- Sits between the vertex fetch stage and the perspective-divide/rasteriser stage.

---
 rtl/mvp_pkg.sv | 18 +
 rtl/vec4_fifo.sv | 66 ++++++
 rtl/mvp_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_mvp_issue_ctrl.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvp_pkg.sv
// Shared types and constants for the MVP transform issue controller.
// The optional WAIT timeout is built only when MM_TIMEOUT_EN is defined.
package mvp_pkg;

    localparam logic [31:0] FLOAT_ONE = 32'h3F800000;

    // Element [0] is x (or row 0); element [3] is w (or row 3).
    typedef logic [3:0][31:0] vec4_t;
    typedef vec4_t [3:0]      mat4_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/vec4_fifo.sv
// Result queue of vec4 words: wrap-around pointers, simultaneous push/pop at
// any fill level, pop-when-empty ignored, head forced to zero when empty.
module vec4_fifo
    import mvp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         push_in,
    input  logic                         pop_in,
    input  vec4_t                        data_in,
    output vec4_t                        data_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic                         full_out,
    output logic                         empty_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    vec4_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_out = (count_q == '0);
    assign full_out  = (count_q == CW'(DEPTH));
    assign count_out = count_q;
    assign data_out  = empty_out ? '0 : mem[rd_ptr_q];

    // A push into a full queue is only taken when the head leaves in the same cycle.
    assign do_pop  = pop_in && !empty_out;
    assign do_push = push_in && (!full_out || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/mvp_issue_ctrl.sv
// Issues one vertex at a time to the 4x4 transform unit and queues its results.
// Define MM_TIMEOUT_EN to abandon a vertex after MAX_WAIT cycles in WAIT.
module mvp_issue_ctrl
    import mvp_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef MM_TIMEOUT_EN
    , parameter int MAX_WAIT = 64
`endif
) (
    input  logic   clk_in,
    input  logic   rst_n_in,
    input  logic   mat_load_in,
    input  mat4_t  mat_in,
    output logic   mat_ready_out,
    input  logic   vert_valid_in,
    output logic   vert_ready_out,
    input  vec4_t  vert_in,
    output logic   mm_valid_out,
    output mat4_t  mm_mat_out,
    output vec4_t  mm_vec_out,
    input  logic   mm_valid_in,
    input  vec4_t  mm_result_in,
    output logic   res_valid_out,
    input  logic   res_ready_in,
    output vec4_t  res_out,
    output logic   busy_out,
    output logic   stray_out,
    output logic   timeout_err_out
);

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n_int;

    state_t state_q, state_d;
    mat4_t  mat_q, mat_d;
    vec4_t  vec_q, vec_d;
    vec4_t  res_q, res_d;
    logic   mm_valid_q, mm_valid_d;
    logic   stray_q, stray_d;
    logic   fifo_push, fifo_full, fifo_empty;
    logic   timed_out;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;

    // Reset asserts immediately but releases two clocks after rst_n_in rises.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n_int  = rst_sync_q[1];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign mat_ready_out  = rst_n_int && (state_q == IDLE);
    assign vert_ready_out = mat_ready_out && !mat_load_in && !fifo_full;
    assign mm_valid_out   = mm_valid_q;
    assign mm_mat_out     = mat_q;
    assign mm_vec_out     = vec_q;
    assign stray_out      = stray_q;
    assign res_valid_out  = !fifo_empty;
    assign busy_out       = (state_q != IDLE) || (fifo_count != '0);

`ifdef MM_TIMEOUT_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);

    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_q, timeout_d;

    assign timed_out       = (state_q == WAIT) && !mm_valid_in && (wait_cnt_q == WCW'(MAX_WAIT - 1));
    assign wait_cnt_d      = (state_q == WAIT) ? wait_cnt_q + WCW'(1) : '0;
    assign timeout_d       = timeout_q || timed_out;
    assign timeout_err_out = timeout_q;

    always_ff @(posedge clk_in or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
`else
    assign timed_out       = 1'b0;
    assign timeout_err_out = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mat_d      = mat_q;
        vec_d      = vec_q;
        res_d      = res_q;
        mm_valid_d = 1'b0;
        fifo_push  = 1'b0;
        stray_d    = mm_valid_in && (state_q != WAIT);
        case (state_q)
            IDLE: begin
                if (mat_load_in && mat_ready_out) begin
                    mat_d = mat_in;
                end else if (vert_valid_in && vert_ready_out) begin
                    vec_d      = vert_in;
                    mm_valid_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mm_valid_in) begin
                    res_d   = mm_result_in;
                    state_d = WRITE;
                end else if (timed_out) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                fifo_push = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= IDLE;
            mat_q      <= '0;
            vec_q      <= '0;
            res_q      <= '0;
            mm_valid_q <= 1'b0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mat_q      <= mat_d;
            vec_q      <= vec_d;
            res_q      <= res_d;
            mm_valid_q <= mm_valid_d;
            stray_q    <= stray_d;
        end
    end

    vec4_fifo #(
        .DEPTH(DEPTH)
    ) u_res_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_int),
        .push_in   (fifo_push),
        .pop_in    (res_ready_in),
        .data_in   (res_q),
        .data_out  (res_out),
        .count_out (fifo_count),
        .full_out  (fifo_full),
        .empty_out (fifo_empty)
    );

endmodule

// File: tb/tb_mvp_issue_ctrl.sv
// Randomized self-checking bench for mvp_issue_ctrl with a behavioural transform model.
// Build with MM_TIMEOUT_EN defined to exercise the WAIT timeout path.
module tb_mvp_issue_ctrl;
    import mvp_pkg::*;

    localparam int DEPTH = 4;
`ifdef MM_TIMEOUT_EN
    localparam int MAX_WAIT = 8;
`endif

    logic  clk = 1'b0;
    logic  rst_n;
    logic  mat_load;
    mat4_t mat_in;
    logic  mat_ready_out;
    logic  vert_valid;
    logic  vert_ready_out;
    vec4_t vert_in;
    logic  mm_valid_out;
    mat4_t mm_mat_out;
    vec4_t mm_vec_out;
    logic  mm_valid_in;
    vec4_t mm_result_in;
    logic  res_valid_out;
    logic  res_ready;
    vec4_t res_out;
    logic  busy_out;
    logic  stray_out;
    logic  timeout_err_out;

    logic  resp_valid, man_valid;
    vec4_t resp_data, man_data;

    int    n_checks = 0;
    int    n_fails  = 0;
    int    issue_cnt = 0;
    int    stray_cnt = 0;
    bit    resp_en = 1'b1;
    int    resp_lat = 4;
    vec4_t exp_q[$];
    mat4_t cur_mat;

    always #5 clk = ~clk;

    assign mm_valid_in  = resp_valid | man_valid;
    assign mm_result_in = man_valid ? man_data : resp_data;

    mvp_issue_ctrl #(
        .DEPTH(DEPTH)
`ifdef MM_TIMEOUT_EN
        , .MAX_WAIT(MAX_WAIT)
`endif
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .mat_load_in     (mat_load),
        .mat_in          (mat_in),
        .mat_ready_out   (mat_ready_out),
        .vert_valid_in   (vert_valid),
        .vert_ready_out  (vert_ready_out),
        .vert_in         (vert_in),
        .mm_valid_out    (mm_valid_out),
        .mm_mat_out      (mm_mat_out),
        .mm_vec_out      (mm_vec_out),
        .mm_valid_in     (mm_valid_in),
        .mm_result_in    (mm_result_in),
        .res_valid_out   (res_valid_out),
        .res_ready_in    (res_ready),
        .res_out         (res_out),
        .busy_out        (busy_out),
        .stray_out       (stray_out),
        .timeout_err_out (timeout_err_out)
    );

    // Integer stand-in for the FP dot product: identity rows pass the vertex through.
    function automatic vec4_t xform(input mat4_t m, input vec4_t v);
        vec4_t r;
        logic [31:0] term;
        for (int i = 0; i < 4; i++) begin
            r[i] = '0;
            for (int c = 0; c < 4; c++) begin
                if (m[i][c] == FLOAT_ONE)  term = v[c];
                else if (m[i][c] == '0)    term = '0;
                else                       term = m[i][c] ^ v[c];
                r[i] = r[i] + term;
            end
        end
        return r;
    endfunction

    function automatic vec4_t rand_vec();
        vec4_t v;
        for (int i = 0; i < 4; i++) v[i] = $urandom;
        return v;
    endfunction

    function automatic mat4_t rand_mat();
        mat4_t m;
        for (int i = 0; i < 4; i++) m[i] = rand_vec();
        return m;
    endfunction

    // Transform unit model: answers each issue after resp_lat cycles.
    initial begin
        resp_valid = 1'b0;
        resp_data  = '0;
        forever begin
            @(negedge clk);
            if (mm_valid_out && resp_en) begin
                repeat (resp_lat) @(negedge clk);
                resp_valid = 1'b1;
                resp_data  = xform(mm_mat_out, mm_vec_out);
                @(negedge clk);
                resp_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mm_valid_out) issue_cnt++;
            if (stray_out)    stray_cnt++;
        end
    end

    task automatic send_vertex(input vec4_t v);
        bit ok = 1'b0;
        @(negedge clk);
        vert_valid = 1'b1;
        vert_in    = v;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (vert_ready_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL send_vertex: vert_ready_out stayed 0, required 1 within 200 cycles");
        end else begin
            exp_q.push_back(xform(cur_mat, v));
        end
        @(negedge clk);
        vert_valid = 1'b0;
    endtask

    task automatic load_matrix(input mat4_t m);
        @(negedge clk);
        mat_load = 1'b1;
        mat_in   = m;
        #1;
        if (mat_ready_out) cur_mat = m;
        @(negedge clk);
        mat_load = 1'b0;
    endtask

    task automatic pop_check(input string name);
        bit    got = 1'b0;
        vec4_t e;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (res_valid_out) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fails++;
            $display("FAIL %s: res_valid_out stayed 0, required 1 within 300 cycles", name);
        end else begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            if (res_out !== e) begin
                n_fails++;
                $display("FAIL %s: res_out=%h required %h", name, res_out, e);
            end else begin
                $display("pop %s: res_out=%h", name, res_out);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mat_ready_out, vert_ready_out, mm_valid_out, res_valid_out, busy_out, stray_out, timeout_err_out} !== 7'b0) begin
            n_fails++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {mat_ready_out, vert_ready_out, mm_valid_out, res_valid_out, busy_out, stray_out, timeout_err_out});
        end
        n_checks++;
        if (mm_mat_out !== '0 || mm_vec_out !== '0 || res_out !== '0) begin
            n_fails++;
            $display("FAIL reset_data: mat=%h vec=%h res=%h required all 0", mm_mat_out, mm_vec_out, res_out);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (mat_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_release: mat_ready=%b busy=%b required 1 0", mat_ready_out, busy_out);
        end
        $display("reset done");
    endtask

    task automatic test_single();
        mat4_t id;
        vec4_t v;
        int    i0;
        bit    seen = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                id[r][c] = (r == c) ? FLOAT_ONE : 32'h0;
        v[0] = 32'h3F800000; v[1] = 32'h40000000; v[2] = 32'h40400000; v[3] = 32'h3F800000;
        resp_lat = 20;
        load_matrix(id);
        n_checks++;
        if (mm_mat_out !== id) begin
            n_fails++;
            $display("FAIL single_mat: mm_mat_out=%h required identity", mm_mat_out);
        end
        i0 = issue_cnt;
        send_vertex(v);
        // send_vertex returns on the cycle after the handshake.
        n_checks++;
        if (mm_valid_out !== 1'b1 || mm_vec_out !== v) begin
            n_fails++;
            $display("FAIL single_issue: mm_valid=%b vec=%h required 1 %h", mm_valid_out, mm_vec_out, v);
        end
        @(negedge clk);
        n_checks++;
        if (mm_valid_out !== 1'b0) begin
            n_fails++;
            $display("FAIL single_pulse: mm_valid_out=%b required 0 one cycle after issue", mm_valid_out);
        end
        for (int k = 0; k < 40; k++) begin
            #1;
            if (mm_valid_in) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (!seen || res_valid_out !== 1'b0) begin
            n_fails++;
            $display("FAIL single_lat1: seen=%b res_valid=%b required 1 0 at R+1", seen, res_valid_out);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid_out !== 1'b1) begin
            n_fails++;
            $display("FAIL single_lat2: res_valid_out=%b required 1 at R+2", res_valid_out);
        end
        pop_check("single");
        n_checks++;
        if (issue_cnt - i0 != 1) begin
            n_fails++;
            $display("FAIL single_count: issued %0d required 1", issue_cnt - i0);
        end
    endtask

    task automatic test_backpressure();
        vec4_t v5, v6, snap;
        int    i0;
        bit    ready_seen = 1'b0;
        res_ready = 1'b0;
        load_matrix(rand_mat());
        resp_lat = $urandom_range(1, 6);
        i0 = issue_cnt;
        for (int i = 0; i < 4; i++) send_vertex(rand_vec());
        v5 = rand_vec();
        v6 = rand_vec();
        @(negedge clk);
        vert_valid = 1'b1;
        vert_in    = v5;
        repeat (30) @(negedge clk);
        snap = res_out;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (vert_ready_out) ready_seen = 1'b1;
        end
        n_checks++;
        if (ready_seen || res_valid_out !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_full: ready_seen=%b res_valid=%b required 0 1", ready_seen, res_valid_out);
        end
        n_checks++;
        if (res_out !== snap) begin
            n_fails++;
            $display("FAIL bp_stable: res_out=%h required %h", res_out, snap);
        end
        n_checks++;
        if (issue_cnt - i0 != 4) begin
            n_fails++;
            $display("FAIL bp_issued: issued %0d required 4", issue_cnt - i0);
        end
        fork
            begin
                send_vertex(v5);
                send_vertex(v6);
            end
            begin
                for (int i = 0; i < 6; i++) pop_check("backpressure");
            end
        join
        n_checks++;
        if (issue_cnt - i0 != 6) begin
            n_fails++;
            $display("FAIL bp_total: issued %0d required 6", issue_cnt - i0);
        end
    endtask

    task automatic test_mat_priority();
        mat4_t m2, m3;
        vec4_t v;
        m2 = rand_mat();
        m3 = rand_mat();
        v  = rand_vec();
        resp_lat = 15;
        @(negedge clk);
        mat_load   = 1'b1;
        mat_in     = m2;
        vert_valid = 1'b1;
        vert_in    = v;
        #1;
        n_checks++;
        if (vert_ready_out !== 1'b0 || mat_ready_out !== 1'b1) begin
            n_fails++;
            $display("FAIL prio_same_cycle: vert_ready=%b mat_ready=%b required 0 1", vert_ready_out, mat_ready_out);
        end
        @(negedge clk);
        mat_load = 1'b0;
        cur_mat  = m2;
        #1;
        n_checks++;
        if (mm_mat_out !== m2 || vert_ready_out !== 1'b1) begin
            n_fails++;
            $display("FAIL prio_next: mat=%h vert_ready=%b required %h 1", mm_mat_out, vert_ready_out, m2);
        end
        exp_q.push_back(xform(m2, v));
        @(negedge clk);
        vert_valid = 1'b0;
        repeat (4) @(negedge clk);
        mat_load = 1'b1;
        mat_in   = m3;
        #1;
        n_checks++;
        if (mat_ready_out !== 1'b0) begin
            n_fails++;
            $display("FAIL prio_wait_ready: mat_ready_out=%b required 0 in WAIT", mat_ready_out);
        end
        @(negedge clk);
        mat_load = 1'b0;
        n_checks++;
        if (mm_mat_out !== m2) begin
            n_fails++;
            $display("FAIL prio_wait_mat: mm_mat_out=%h required %h", mm_mat_out, m2);
        end
        pop_check("mat_priority");
    endtask

    task automatic test_stray();
        int s0;
        repeat (2) @(negedge clk);
        s0 = stray_cnt;
        man_valid = 1'b1;
        man_data  = rand_vec();
        @(negedge clk);
        man_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (stray_cnt - s0 != 1 || res_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fails++;
            $display("FAIL stray_idle: pulses=%0d res_valid=%b busy=%b required 1 0 0",
                     stray_cnt - s0, res_valid_out, busy_out);
        end
    endtask

    task automatic test_reset_wait();
        int s0;
        resp_en = 1'b0;
        send_vertex(rand_vec());
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy_out !== 1'b1) begin
            n_fails++;
            $display("FAIL rstwait_busy: busy_out=%b required 1 in WAIT", busy_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mat_ready_out, vert_ready_out, mm_valid_out, res_valid_out, busy_out, stray_out} !== 6'b0
            || mm_vec_out !== '0 || mm_mat_out !== '0) begin
            n_fails++;
            $display("FAIL rstwait_async: flags=%b vec=%h required all 0",
                     {mat_ready_out, vert_ready_out, mm_valid_out, res_valid_out, busy_out, stray_out}, mm_vec_out);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        cur_mat = '0;
        repeat (3) @(negedge clk);
        s0 = stray_cnt;
        man_valid = 1'b1;
        man_data  = rand_vec();
        @(negedge clk);
        man_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (stray_cnt - s0 != 1 || res_valid_out !== 1'b0) begin
            n_fails++;
            $display("FAIL rstwait_late: pulses=%0d res_valid=%b required 1 0", stray_cnt - s0, res_valid_out);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_timeout();
`ifdef MM_TIMEOUT_EN
        int s0;
        resp_en = 1'b0;
        send_vertex(rand_vec());
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        // Now in the ISSUE cycle; WAIT occupies the next MAX_WAIT cycles.
        for (int k = 2; k <= MAX_WAIT + 2; k++) begin
            @(negedge clk);
            if (k == MAX_WAIT + 1) begin
                n_checks++;
                if (timeout_err_out !== 1'b0) begin
                    n_fails++;
                    $display("FAIL timeout_early: timeout_err_out=%b required 0 in last WAIT cycle", timeout_err_out);
                end
            end
        end
        n_checks++;
        if (timeout_err_out !== 1'b1 || mat_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_fire: err=%b mat_ready=%b busy=%b required 1 1 0",
                     timeout_err_out, mat_ready_out, busy_out);
        end
        s0 = stray_cnt;
        man_valid = 1'b1;
        man_data  = rand_vec();
        @(negedge clk);
        man_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (stray_cnt - s0 != 1 || res_valid_out !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_late: pulses=%0d res_valid=%b required 1 0", stray_cnt - s0, res_valid_out);
        end
        resp_en  = 1'b1;
        resp_lat = 3;
        send_vertex(rand_vec());
        pop_check("after_timeout");
        n_checks++;
        if (timeout_err_out !== 1'b1) begin
            n_fails++;
            $display("FAIL timeout_sticky: timeout_err_out=%b required 1", timeout_err_out);
        end
`else
        vec4_t d;
        resp_en = 1'b0;
        send_vertex(rand_vec());
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        repeat (100) @(negedge clk);
        n_checks++;
        if (timeout_err_out !== 1'b0 || busy_out !== 1'b1 || mat_ready_out !== 1'b0) begin
            n_fails++;
            $display("FAIL hold_wait: err=%b busy=%b mat_ready=%b required 0 1 0",
                     timeout_err_out, busy_out, mat_ready_out);
        end
        d = rand_vec();
        man_valid = 1'b1;
        man_data  = d;
        exp_q.push_back(d);
        @(negedge clk);
        man_valid = 1'b0;
        pop_check("late_result");
        resp_en = 1'b1;
`endif
    endtask

    task automatic test_random();
        mat4_t m;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                m = rand_mat();
                load_matrix(m);
                n_checks++;
                if (mm_mat_out !== m) begin
                    n_fails++;
                    $display("FAIL random_mat: mm_mat_out=%h required %h", mm_mat_out, m);
                end
            end
            resp_lat = $urandom_range(1, 10);
            send_vertex(rand_vec());
            pop_check("random");
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        mat_load   = 1'b0;
        mat_in     = '0;
        vert_valid = 1'b0;
        vert_in    = '0;
        res_ready  = 1'b0;
        man_valid  = 1'b0;
        man_data   = '0;
        cur_mat    = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_mat_priority();
        test_stray();
        test_reset_wait();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
